// File: rtl/memory_access_controller.sv
// rtl/memory_access_controller.sv - single-outstanding load/store/output sequencer for the memory FU (optional watchdog: MEMCTL_TIMEOUT_EN)
module memory_access_controller #(
    parameter int MEM_ADDR_W     = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INSTR_W        = 8,
    parameter int RSV_ID_W       = 4,
    parameter int DATA_W         = 32,
    parameter int CDB_W          = RSV_ID_W + DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [INSTR_W-1:0]    i_opcode,
    input  logic [RSV_ID_W-1:0]   i_rsv_id,
    input  logic [DATA_W-1:0]     i_address,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  i_ready,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic [CDB_W-1:0]      o_cdb,
    output logic                  o_cdb_valid,
    input  logic                  o_cdb_ready,
    output logic                  busy,
    output logic [1:0]            err
);

    // Opcode encodings of the memory-class instructions
    localparam logic [INSTR_W-1:0] I_STORE   = INSTR_W'(8'h10);
    localparam logic [INSTR_W-1:0] I_STOREB  = INSTR_W'(8'h11);
    localparam logic [INSTR_W-1:0] I_STORER  = INSTR_W'(8'h12);
    localparam logic [INSTR_W-1:0] I_STOREF  = INSTR_W'(8'h13);
    localparam logic [INSTR_W-1:0] I_STOREBF = INSTR_W'(8'h14);
    localparam logic [INSTR_W-1:0] I_STORERF = INSTR_W'(8'h15);
    localparam logic [INSTR_W-1:0] I_OUTPUT  = INSTR_W'(8'h20);

    localparam logic [1:0] CLS_LOAD   = 2'd0;
    localparam logic [1:0] CLS_STORE  = 2'd1;
    localparam logic [1:0] CLS_OUTPUT = 2'd2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MEM_REQ  = 3'd1;
    localparam logic [2:0] S_MEM_WAIT = 3'd2;
    localparam logic [2:0] S_CDB_OUT  = 3'd3;
    localparam logic [2:0] S_OUT_REQ  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [1:0]            cls_q, in_cls;
    logic [RSV_ID_W-1:0]   rsv_id_q;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err0_q;
    logic                  err1;
    logic                  timeout_hit;
    logic                  timeout_abort;

    // Upper address bits beyond the memory window are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_address[DATA_W-1:MEM_ADDR_W];

    // Classify the incoming opcode; anything not a store or output is a load
    always_comb begin
        in_cls = CLS_LOAD;
        case (i_opcode)
            I_STORE, I_STOREB, I_STORER,
            I_STOREF, I_STOREBF, I_STORERF: in_cls = CLS_STORE;
            I_OUTPUT:                       in_cls = CLS_OUTPUT;
            default:                        in_cls = CLS_LOAD;
        endcase
    end

`ifdef MEMCTL_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q;
    logic        err1_q;

    // Watchdog: fires on the cycle the count would reach the limit
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    // Count cycles spent in a waiting state; restart on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if (state_d != state_q) begin
            cnt_q <= 16'd0;
        end else if (state_q == S_MEM_REQ || state_q == S_MEM_WAIT || state_q == S_OUT_REQ) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err1_q <= 1'b0;
        end else if (timeout_abort) begin
            err1_q <= 1'b1;
        end
    end

    assign err1 = err1_q;
`else
    assign timeout_hit = 1'b0;
    assign err1        = 1'b0;
`endif

    // Next-state logic; a handshake always wins over a same-cycle timeout
    always_comb begin
        state_d       = state_q;
        timeout_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d = (in_cls == CLS_OUTPUT) ? S_OUT_REQ : S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_d = (cls_q == CLS_STORE) ? S_IDLE : S_MEM_WAIT;
                end else if (timeout_hit) begin
                    timeout_abort = 1'b1;
                    state_d       = (cls_q == CLS_LOAD) ? S_CDB_OUT : S_IDLE;
                end
            end
            S_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = S_CDB_OUT;
                end else if (timeout_hit) begin
                    timeout_abort = 1'b1;
                    state_d       = S_CDB_OUT;
                end
            end
            S_CDB_OUT: begin
                if (o_cdb_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_OUT_REQ: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    timeout_abort = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request on acceptance; held until the access retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_q    <= CLS_LOAD;
            rsv_id_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (state_q == S_IDLE && i_valid) begin
            cls_q    <= in_cls;
            rsv_id_q <= i_rsv_id;
            addr_q   <= i_address[MEM_ADDR_W-1:0];
            data_q   <= i_data;
        end
    end

    // Capture load data; an aborted load retires with zero data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_q == S_MEM_WAIT && mem_rsp_valid) begin
            rdata_q <= mem_rdata;
        end else if (timeout_abort) begin
            rdata_q <= '0;
        end
    end

    // Sticky flag for a read response arriving when none is outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err0_q <= 1'b0;
        end else if (mem_rsp_valid && state_q != S_MEM_WAIT) begin
            err0_q <= 1'b1;
        end
    end

    assign i_ready       = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign mem_req_valid = (state_q == S_MEM_REQ);
    assign mem_we        = (state_q == S_MEM_REQ) && (cls_q == CLS_STORE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = data_q;
    assign out_valid     = (state_q == S_OUT_REQ);
    assign out_data      = data_q;
    assign o_cdb_valid   = (state_q == S_CDB_OUT);
    assign o_cdb         = {rsv_id_q, rdata_q};
    assign err           = {err1, err0_q};

endmodule

// File: tb/tb_memory_access_controller.sv
// tb/tb_memory_access_controller.sv - directed self-checking bench for memory_access_controller
module tb_memory_access_controller;

    localparam logic [7:0] I_LOAD    = 8'h08;
    localparam logic [7:0] I_STORE   = 8'h10;
    localparam logic [7:0] I_STOREBF = 8'h14;
    localparam logic [7:0] I_OUTPUT  = 8'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [7:0]  i_opcode;
    logic [3:0]  i_rsv_id;
    logic [31:0] i_address;
    logic [31:0] i_data;
    logic        i_ready;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [35:0] o_cdb;
    logic        o_cdb_valid;
    logic        o_cdb_ready;
    logic        busy;
    logic [1:0]  err;

    int tests = 0;
    int fails = 0;

    memory_access_controller #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_opcode(i_opcode), .i_rsv_id(i_rsv_id),
        .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [3:0] id,
                         input logic [31:0] addr, input logic [31:0] data);
        i_valid   = 1'b1;
        i_opcode  = op;
        i_rsv_id  = id;
        i_address = addr;
        i_data    = data;
    endtask

    task automatic drop_req();
        i_valid   = 1'b0;
        i_opcode  = 8'h00;
        i_rsv_id  = 4'h0;
        i_address = 32'h0;
        i_data    = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        drop_req();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        out_ready     = 1'b0;
        o_cdb_ready   = 1'b0;
        #1;
        check("rst_i_ready", i_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 2'b00);
        check("rst_valids", {mem_req_valid, out_valid, o_cdb_valid}, 3'b000);
        step();
        step();
        rst = 1'b0;

        // Store with immediate memory acceptance; upper address bits dropped
        mem_req_ready = 1'b1;
        issue(I_STORE, 4'd1, 32'h0001_0004, 32'hDEAD_BEEF);
        step();
        drop_req();
        check("st_c1_req_valid", mem_req_valid, 1);
        check("st_c1_we", mem_we, 1);
        check("st_c1_addr", mem_addr, 16'h0004);
        check("st_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st_c1_cdb_valid", o_cdb_valid, 0);
        check("st_c1_i_ready", i_ready, 0);
        step();
        check("st_c2_i_ready", i_ready, 1);
        check("st_c2_req_valid", mem_req_valid, 0);

        // Back-to-back store of another store variant
        issue(I_STOREBF, 4'd2, 32'h0000_0100, 32'h0000_00AB);
        step();
        drop_req();
        check("st2_we", mem_we, 1);
        check("st2_addr", mem_addr, 16'h0100);
        step();
        check("st2_done", i_ready, 1);

        // Load with a 3-cycle request stall, response two cycles after acceptance
        mem_req_ready = 1'b0;
        issue(I_LOAD, 4'd5, 32'h0000_0020, 32'h0);
        step();
        drop_req();
        for (int c = 1; c <= 3; c++) begin
            check("ld_stall_valid", mem_req_valid, 1);
            check("ld_stall_we", mem_we, 0);
            check("ld_stall_addr", mem_addr, 16'h0020);
            if (c < 3) step();
        end
        step();
        mem_req_ready = 1'b1;
        check("ld_hs_valid", mem_req_valid, 1);
        step();
        mem_req_ready = 1'b0;
        check("ld_wait_req_low", mem_req_valid, 0);
        check("ld_wait_busy", busy, 1);
        step();
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        check("ld_wait_no_cdb", o_cdb_valid, 0);
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        for (int c = 0; c < 4; c++) begin
            check("ld_cdb_valid", o_cdb_valid, 1);
            check("ld_cdb_word", o_cdb, {4'd5, 32'h1234_5678});
            check("ld_cdb_i_ready", i_ready, 0);
            if (c < 3) step();
        end
        o_cdb_ready = 1'b1;
        step();
        o_cdb_ready = 1'b0;
        check("ld_retired_valid", o_cdb_valid, 0);
        check("ld_retired_i_ready", i_ready, 1);

        // Output write with the device stalling two cycles
        issue(I_OUTPUT, 4'd7, 32'h0000_0000, 32'h0000_0041);
        step();
        drop_req();
        for (int c = 0; c < 3; c++) begin
            check("out_valid", out_valid, 1);
            check("out_data", out_data, 32'h41);
            check("out_no_mem", mem_req_valid, 0);
            if (c == 2) out_ready = 1'b1;
            else step();
        end
        step();
        out_ready = 1'b0;
        check("out_done_valid", out_valid, 0);
        check("out_done_i_ready", i_ready, 1);

        // Spurious read response in IDLE
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hFFFF_FFFF;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        check("spur_err", err, 2'b01);
        check("spur_idle", busy, 0);
        step();
        check("spur_sticky", err, 2'b01);

        // Reset asserted while a load waits for its response
        mem_req_ready = 1'b1;
        issue(I_LOAD, 4'd9, 32'h0000_0030, 32'h0);
        step();
        drop_req();
        step();
        check("mid_in_wait", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valids", {mem_req_valid, out_valid, o_cdb_valid}, 3'b000);
        check("mid_rst_err", err, 2'b00);
        check("mid_rst_cdb", o_cdb, 36'h0);
        step();
        rst = 1'b0;
        check("mid_rel_i_ready", i_ready, 1);
        issue(I_LOAD, 4'd3, 32'hFFFF_0044, 32'h0);
        step();
        drop_req();
        check("post_req_valid", mem_req_valid, 1);
        check("post_addr", mem_addr, 16'h0044);
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hAABB_CCDD;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        check("post_cdb_valid", o_cdb_valid, 1);
        check("post_cdb_word", o_cdb, {4'd3, 32'hAABB_CCDD});
        o_cdb_ready = 1'b1;
        step();
        o_cdb_ready = 1'b0;
        check("post_idle", i_ready, 1);
        check("post_err", err, 2'b00);

`ifdef MEMCTL_TIMEOUT_EN
        // Load whose request is never accepted: aborts after 8 cycles in MEM_REQ
        mem_req_ready = 1'b0;
        issue(I_LOAD, 4'd6, 32'h0000_0050, 32'h0);
        step();
        drop_req();
        for (int c = 1; c < 8; c++) step();
        check("to_c8_err", err, 2'b00);
        check("to_c8_req", mem_req_valid, 1);
        step();
        check("to_c9_err", err, 2'b10);
        check("to_c9_cdb_valid", o_cdb_valid, 1);
        check("to_c9_cdb", o_cdb, {4'd6, 32'h0});
        o_cdb_ready = 1'b1;
        step();
        o_cdb_ready = 1'b0;
        check("to_idle", i_ready, 1);
`else
        // Without the watchdog a stalled request waits indefinitely
        mem_req_ready = 1'b0;
        issue(I_LOAD, 4'd6, 32'h0000_0050, 32'h0);
        step();
        drop_req();
        for (int c = 1; c < 12; c++) step();
        check("nto_still_req", mem_req_valid, 1);
        check("nto_err", err, 2'b00);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0000_5A5A;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        check("nto_cdb", o_cdb, {4'd6, 32'h0000_5A5A});
        o_cdb_ready = 1'b1;
        step();
        o_cdb_ready = 1'b0;
        check("nto_idle", i_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
Sequences the memory functional unit's issue stream (valid/opcode/rsv_id/address/data) onto one shared single-port data memory and one output device. Keeps at most one access in flight. Returns load results to the CDB arbiter as a CDB_W word {rsv_id, data}; stores and output complete silently. Sits between the memory functional unit and the data memory / IO block.

Parameters:
MEM_ADDR_W, 16, width of mem_addr; low MEM_ADDR_W bits of i_address, upper bits ignored
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature), 1..65535

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_valid  in  1  request from memory functional unit
i_opcode  in  INSTR_W  instruction opcode
i_rsv_id  in  RSV_ID_W  ROB/reservation tag
i_address  in  DATA_W  computed address
i_data  in  DATA_W  store/output data
i_ready  out  1  request accepted when i_valid&i_ready
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_we  out  1  1=write, 0=read
mem_addr  out  MEM_ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_rsp_valid  in  1  read data valid (one pulse per read)
mem_rdata  in  DATA_W  read data
out_valid  out  1  output-device write
out_data  out  DATA_W  output-device data
out_ready  in  1  output device accepts
o_cdb  out  CDB_W  {rsv_id, load data}
o_cdb_valid  out  1  CDB result valid
o_cdb_ready  in  1  CDB arbiter grant
busy  out  1  state != IDLE
err  out  2  sticky: bit0 spurious mem_rsp_valid, bit1 timeout

Behaviour:
- Opcode class: I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF -> STORE; I_OUTPUT -> OUTPUT; everything else -> LOAD.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, CDB_OUT, OUT_REQ.
- i_ready = (state==IDLE). On accept, latch opcode class, rsv_id, address, data.
- IDLE -> MEM_REQ for STORE/LOAD; IDLE -> OUT_REQ for OUTPUT.
- MEM_REQ:
  - mem_req_valid=1; mem_we=1 for STORE, 0 for LOAD.
  - mem_addr, mem_wdata come from registers and stay stable until mem_req_ready.
  - On handshake: STORE -> IDLE; LOAD -> MEM_WAIT.
- MEM_WAIT: on mem_rsp_valid, capture mem_rdata -> CDB_OUT.
- CDB_OUT: o_cdb_valid=1, o_cdb={rsv_id, rdata} held stable; on o_cdb_ready -> IDLE.
- OUT_REQ: out_valid=1, out_data held stable; on out_ready -> IDLE.
- Latency (accept at cycle 0):
  - mem_req_valid first high at cycle 1.
  - Store with mem_req_ready=1 at cycle 1: i_ready high at cycle 2.
  - Load with response at cycle 2: o_cdb_valid at cycle 3.
- All outputs are registered or decoded from state; no combinational path from i_valid.
- mem_rsp_valid in any state other than MEM_WAIT: ignored, err[0] set.
- err bits are sticky until reset.
- Reset (asynchronous, any time, including mid-access): state=IDLE, all valids 0, i_ready=1 after release, busy=0, err=0, all data/address registers 0. An in-flight request is dropped; the memory must be reset together.
- Back-to-back: no idle bubble is required beyond returning to IDLE (one request per 2 cycles minimum for stores).

Optional Feature:
MEMCTL_TIMEOUT_EN:
- Defined:
  - A 16-bit counter clears on every state entry and increments each cycle in MEM_REQ, MEM_WAIT and OUT_REQ.
  - When the counter reaches TIMEOUT_CYCLES: set err[1] and abort.
    - LOAD abort: go to CDB_OUT with data 0, so the tag still retires.
    - STORE/OUTPUT abort: go to IDLE.
  - A late mem_rsp_valid after abort sets err[0].
- Undefined: no counter; the FSM waits indefinitely; err[1] is tied to 0.

Test Plan:
- Reset mid-access: assert rst during MEM_WAIT -> immediately state=IDLE, all valids 0, err=0; after release, a new load completes normally.
- Store I_STORE, addr 0x00010004, data 0xDEADBEEF, mem_req_ready=1 -> cycle 1: mem_req_valid=1, mem_we=1, mem_addr=0x0004, mem_wdata=0xDEADBEEF; no o_cdb_valid; i_ready=1 at cycle 2.
- Load, rsv_id 5, addr 0x20, mem_req_ready stalled 3 cycles, rdata 0x12345678 two cycles later -> mem_addr stable during the stall; o_cdb={5, 0x12345678}; o_cdb_ready held 0 for 4 cycles keeps o_cdb stable; i_ready stays 0 until the grant.
- I_OUTPUT, data 0x41, out_ready delayed 2 cycles -> out_valid=1, out_data=0x41 for 3 cycles; mem_req_valid stays 0.
- mem_rsp_valid pulse while in IDLE -> err=2'b01; the FSM does not move.
- MEMCTL_TIMEOUT_EN, TIMEOUT_CYCLES=8, load never answered -> cycle 9 after the request: err[1]=1, o_cdb={tag, 0} valid, then IDLE.
